cdb_arbiter: RTL and testbench

//  Shares the single common data bus (CDB) result/broadcast path among the execution units.
//  - Requesters: ALU, LSU, branch unit.
//  - One winner per cycle, chosen round-robin; its {tag,data} goes into a registered CDB slot.
//  - The CDB slot is read by the ROB and the reservation stations.
//  - Sits between EX/writeback and the ROB write port.
//  - Honours ROB back-pressure (cdb_stall) and pipeline flush.

---
 rtl/cdb_pkg.sv | 23 ++
 rtl/cdb_arbiter_if.sv | 26 ++
 rtl/cdb_arbiter_rr.sv | 40 ++++
 rtl/cdb_arbiter.sv | 72 +++++++
 tb/tb_cdb_arbiter.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cdb_pkg.sv
// Shared CDB types and sizing: requester count, tag/data widths and unit indices.
package cdb_pkg;

   localparam int unsigned N_REQ     = 3;
   localparam int unsigned TAG_W     = 5;
   localparam int unsigned DATA_W    = 32;
   localparam int unsigned CDB_SRC_W = $clog2(N_REQ);

   localparam int unsigned CDB_SRC_ALU = 0;
   localparam int unsigned CDB_SRC_LSU = 1;
   localparam int unsigned CDB_SRC_BRU = 2;

   typedef struct packed {
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] data;
   } cdb_entry_t;

   // Round-robin successor of a granted index, wrapping at the last unit
   function automatic logic [CDB_SRC_W-1:0] next_ptr(input logic [CDB_SRC_W-1:0] idx);
      return (32'(idx) == N_REQ - 1) ? '0 : CDB_SRC_W'(32'(idx) + 32'd1);
   endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Execution-unit request side and CDB broadcast side of the result bus.
interface cdb_arbiter_if;
   import cdb_pkg::*;

   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ*TAG_W-1:0]  req_tag;
   logic [N_REQ*DATA_W-1:0] req_data;
   logic [N_REQ-1:0]        req_ready;
   logic                    cdb_stall;
   logic                    flush;
   logic                    cdb_valid;
   logic [TAG_W-1:0]        cdb_tag;
   logic [DATA_W-1:0]       cdb_data;
   logic [CDB_SRC_W-1:0]    cdb_src;

   modport slave (
      input  req_valid, req_tag, req_data, cdb_stall, flush,
      output req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
   );

   modport master (
      output req_valid, req_tag, req_data, cdb_stall, flush,
      input  req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
   );

endinterface

// File: rtl/cdb_arbiter_rr.sv
// Combinational round-robin arbiter: lowest set request at or after ptr, searched
// over a doubled request vector so the wrap needs no separate pass.
module rr_arbiter #(
   parameter int unsigned N     = 3,
   parameter int unsigned IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   input  logic             en,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] gnt_idx
);

   localparam int unsigned W2 = 2 * N;

   logic [W2-1:0] req2;
   logic [W2-1:0] mask;
   logic [W2-1:0] masked;
   logic [W2-1:0] gnt2;
   logic          found;

   always_comb begin
      req2    = {req, req};
      mask    = ~((W2'(1) << ptr) - W2'(1));
      masked  = req2 & mask;
      gnt2    = '0;
      gnt_idx = '0;
      found   = 1'b0;
      for (int unsigned k = 0; k < W2; k++) begin
         if (en && !found && masked[k]) begin
            found   = 1'b1;
            gnt2[k] = 1'b1;
            gnt_idx = IDX_W'((k >= N) ? k - N : k);
         end
      end
      // Fold the upper (wrapped) half back onto the unit indices
      gnt = gnt2[N-1:0] | gnt2[W2-1:N];
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Picks one execution-unit result per cycle round-robin and holds it in the
// registered CDB slot; ROB stall holds the slot, flush kills it.
module cdb_arbiter
   import cdb_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   cdb_arbiter_if.slave  bus
);

   logic [CDB_SRC_W-1:0] rr_ptr;
   logic [CDB_SRC_W-1:0] gnt_idx;
   logic [N_REQ-1:0]     gnt;
   logic                 grant_en;
   cdb_entry_t           win;
   cdb_entry_t           slot;
   logic                 slot_valid;
   logic [CDB_SRC_W-1:0] slot_src;

   assign grant_en = rst & ~bus.cdb_stall & ~bus.flush;

   rr_arbiter #(
      .N     (N_REQ),
      .IDX_W (CDB_SRC_W)
   ) u_rr (
      .req     (bus.req_valid),
      .ptr     (rr_ptr),
      .en      (grant_en),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign bus.req_ready = gnt;

   // Winner's payload mux, driven from the one-hot grant only
   always_comb begin
      win = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (gnt[i]) begin
            win.tag  = bus.req_tag[i*TAG_W +: TAG_W];
            win.data = bus.req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // CDB slot and pointer; the grant is already suppressed under stall/flush
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         slot_valid <= 1'b0;
         slot       <= '0;
         slot_src   <= '0;
         rr_ptr     <= '0;
      end else if (bus.flush) begin
         slot_valid <= 1'b0;
      end else if (!bus.cdb_stall) begin
         if (|gnt) begin
            slot_valid <= 1'b1;
            slot       <= win;
            slot_src   <= gnt_idx;
            rr_ptr     <= next_ptr(gnt_idx);
         end else begin
            slot_valid <= 1'b0;
         end
      end
   end

   assign bus.cdb_valid = slot_valid;
   assign bus.cdb_tag   = slot.tag;
   assign bus.cdb_data  = slot.data;
   assign bus.cdb_src   = slot_src;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: requester/ROB model with a broadcast scoreboard,
// directed reset/stall/flush/wrap cases and a random fairness run.
module tb_cdb_arbiter;
   import cdb_pkg::*;

   typedef struct packed {
      logic [CDB_SRC_W-1:0] src;
      cdb_entry_t           e;
   } bcast_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   cdb_arbiter_if bus ();

   cdb_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int unsigned          n_checks  = 0;
   int unsigned          n_errors  = 0;
   int unsigned          n_issued  = 0;
   int unsigned          n_bcast   = 0;
   int unsigned          n_dropped = 0;
   logic [N_REQ-1:0]     v         = '0;
   logic [TAG_W-1:0]     tg [N_REQ];
   logic [DATA_W-1:0]    dt [N_REQ];
   int                   wait_cnt [N_REQ];
   logic                 stall     = 1'b0;
   logic                 fl        = 1'b0;
   logic [TAG_W-1:0]     tag_ctr   = '0;
   bcast_t               sb_q [$];
   bcast_t               last_b    = '0;
   logic [CDB_SRC_W-1:0] m_ptr     = '0;
   logic                 m_valid   = 1'b0;
   logic                 pushed    = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic new_entry(input int i);
      v[i]    = 1'b1;
      tg[i]   = tag_ctr;
      tag_ctr = tag_ctr + 1'b1;
      dt[i]   = $urandom();
      n_issued++;
   endtask

   task automatic drop_all();
      for (int i = 0; i < N_REQ; i++) begin
         if (v[i]) begin
            v[i] = 1'b0;
            n_dropped++;
         end
      end
   endtask

   task automatic drive();
      bus.req_valid = v;
      for (int i = 0; i < N_REQ; i++) begin
         bus.req_tag[i*TAG_W +: TAG_W]    = tg[i];
         bus.req_data[i*DATA_W +: DATA_W] = dt[i];
      end
      bus.cdb_stall = stall;
      bus.flush     = fl;
   endtask

   // One clock: check last edge's broadcast and this cycle's grant, then advance
   task automatic cycle();
      logic [N_REQ-1:0] eg;
      int               gi;
      logic             nv;
      logic             np;
      drive();
      @(negedge clk);
      if (pushed && sb_q.size() > 0) begin
         last_b = sb_q.pop_front();
         n_bcast++;
      end
      check("cdb_valid", 64'(bus.cdb_valid), 64'(m_valid));
      if (m_valid) begin
         check("cdb_tag",  64'(bus.cdb_tag),  64'(last_b.e.tag));
         check("cdb_data", 64'(bus.cdb_data), 64'(last_b.e.data));
         check("cdb_src",  64'(bus.cdb_src),  64'(last_b.src));
      end
      eg = '0;
      gi = -1;
      if (rst && !stall && !fl) begin
         for (int k = 0; k < N_REQ; k++) begin
            int idx;
            idx = (int'(m_ptr) + k) % N_REQ;
            if (gi < 0 && v[idx]) gi = idx;
         end
      end
      if (gi >= 0) eg[gi] = 1'b1;
      check("req_ready", 64'(bus.req_ready), 64'(eg));
      check("onehot", 64'($onehot0(bus.req_ready)), 64'd1);
      if (rst && !stall && !fl) begin
         for (int i = 0; i < N_REQ; i++) begin
            if (v[i]) begin
               if (eg[i]) begin
                  check("fair_wait", 64'(wait_cnt[i] < N_REQ), 64'd1);
                  wait_cnt[i] = 0;
               end else begin
                  wait_cnt[i]++;
               end
            end
         end
      end
      nv = m_valid;
      np = 1'b0;
      if (!rst) begin
         nv    = 1'b0;
         m_ptr = '0;
      end else if (fl) begin
         nv = 1'b0;
      end else if (!stall) begin
         if (gi >= 0) begin
            sb_q.push_back('{src: CDB_SRC_W'(gi), e: '{tag: tg[gi], data: dt[gi]}});
            np    = 1'b1;
            nv    = 1'b1;
            m_ptr = (gi == N_REQ - 1) ? '0 : CDB_SRC_W'(gi + 1);
         end else begin
            nv = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      m_valid = nv;
      pushed  = np;
      if (gi >= 0) v[gi] = 1'b0;
      if (fl) begin
         drop_all();
         for (int i = 0; i < N_REQ; i++) wait_cnt[i] = 0;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < N_REQ; i++) begin
         tg[i]       = '0;
         dt[i]       = '0;
         wait_cnt[i] = 0;
      end
      drive();
      #1 rst = 1'b0;

      // Reset holds grants off even with every unit requesting
      for (int i = 0; i < N_REQ; i++) new_entry(i);
      repeat (2) cycle();
      check("rst_ready", 64'(bus.req_ready), 64'd0);
      check("rst_valid", 64'(bus.cdb_valid), 64'd0);
      rst = 1'b1;

      // All busy: grants rotate 0,1,2,0,1,2 starting from unit 0
      for (int k = 0; k < 6; k++) begin
         cycle();
         check("busy_src", 64'(bus.cdb_src), 64'(k % N_REQ));
         for (int i = 0; i < N_REQ; i++) if (!v[i]) new_entry(i);
      end

      // Stall: broadcast from the LSU is held, nothing granted, pointer parked at 2
      drop_all();
      new_entry(CDB_SRC_LSU);
      tg[CDB_SRC_LSU] = 5'h0A;
      dt[CDB_SRC_LSU] = 32'hDEADBEEF;
      cycle();
      check("lsu_src", 64'(bus.cdb_src), 64'(CDB_SRC_LSU));
      stall = 1'b1;
      for (int i = 0; i < N_REQ; i++) if (!v[i]) new_entry(i);
      repeat (3) begin
         cycle();
         check("stall_tag",   64'(bus.cdb_tag),   64'h0A);
         check("stall_data",  64'(bus.cdb_data),  64'hDEADBEEF);
         check("stall_ready", 64'(bus.req_ready), 64'd0);
      end
      stall = 1'b0;
      cycle();
      check("unstall_src", 64'(bus.cdb_src), 64'(CDB_SRC_BRU));

      // Flush together with stall kills the live broadcast
      fl    = 1'b1;
      stall = 1'b1;
      cycle();
      check("flush_valid", 64'(bus.cdb_valid), 64'd0);
      check("flush_ready", 64'(bus.req_ready), 64'd0);
      fl    = 1'b0;
      stall = 1'b0;
      for (int i = 0; i < N_REQ; i++) new_entry(i);
      cycle();
      check("post_flush_src", 64'(bus.cdb_src), 64'(CDB_SRC_ALU));

      // Sparse: BRU alone, pointer wraps to 0, ALU is served next
      drop_all();
      new_entry(CDB_SRC_BRU);
      cycle();
      new_entry(CDB_SRC_BRU);
      cycle();
      check("sparse_bru", 64'(bus.cdb_src), 64'(CDB_SRC_BRU));
      new_entry(CDB_SRC_ALU);
      new_entry(CDB_SRC_BRU);
      cycle();
      check("wrap_alu", 64'(bus.cdb_src), 64'(CDB_SRC_ALU));

      // Reset mid-broadcast drops cdb_valid without waiting for a clock
      check("pre_rst_valid", 64'(bus.cdb_valid), 64'd1);
      rst = 1'b0;
      #1;
      check("async_rst_valid", 64'(bus.cdb_valid), 64'd0);
      check("async_rst_ready", 64'(bus.req_ready), 64'd0);
      if (pushed && sb_q.size() > 0) begin
         last_b = sb_q.pop_front();
         n_bcast++;
      end
      pushed  = 1'b0;
      m_valid = 1'b0;
      m_ptr   = '0;
      for (int i = 0; i < N_REQ; i++) wait_cnt[i] = 0;
      #1 rst = 1'b1;

      // Random requests and stalls
      for (int c = 0; c < 10000; c++) begin
         for (int i = 0; i < N_REQ; i++) begin
            if (!v[i] && ($urandom_range(0, 1) == 1)) new_entry(i);
         end
         stall = ($urandom_range(0, 3) == 0);
         cycle();
      end
      stall = 1'b0;
      repeat (N_REQ + 2) cycle();

      check("drain_queue", 64'(sb_q.size()), 64'd0);
      check("drain_valid", 64'(v), 64'd0);
      check("tag_accounting", 64'(n_issued), 64'(n_bcast + n_dropped));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
